// File: rtl/b2_serial_adder.sv
// Bit-serial adder: {cout, s} = x + y + cin, one bit per clock, LSB first,
// built from a single full-adder cell and a carry flip-flop. start/done handshake.
module b2_serial_adder #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-adder cell as two half adders plus OR; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic h;
    h = a ^ b;
    return {(a & b) | (c & h), h ^ c};
  endfunction

  state_t        state_r;
  logic [N-1:0]  x_r;
  logic [N-1:0]  y_r;
  logic [N-1:0]  s_r;
  logic          c_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic          done_r;

  logic [1:0]    fa_s;
  logic [N:0]    s_shift_s;

  // Bit cell and the sum register shifted with the new bit entering at the MSB.
  always_comb begin
    fa_s      = full_add(x_r[0], y_r[0], c_r);
    s_shift_s = {fa_s[0], s_r};
  end

  // Control FSM plus operand, carry, sum and counter registers.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_r <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      s_r     <= '0;
      c_r     <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            x_r     <= x;
            y_r     <= y;
            c_r     <= cin;
            s_r     <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ADD;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ADD: begin
          s_r   <= s_shift_s[N:1];
          x_r   <= x_r >> 1'b1;
          y_r   <= y_r >> 1'b1;
          c_r   <= fa_s[1];
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ADD;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign s    = s_r;
  assign cout = c_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
